// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_divider_addsub.sv
// Parameterised ripple-carry adder/subtractor: ctrl=1 inverts b and injects a
// carry-in, so sum = a - b and cout=1 means no borrow (a >= b).
module addsub_nbit #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         ctrl,
   output logic [N-1:0] sum,
   output logic         cout
);

   logic [N-1:0] b_x;
   logic [N:0]   carry;

   assign b_x = b ^ {N{ctrl}};

   always_comb begin
      carry[0] = ctrl;
      for (int i = 0; i < N; i++) begin
         sum[i]       = a[i] ^ b_x[i] ^ carry[i];
         carry[i + 1] = (a[i] & b_x[i]) | (carry[i] & (a[i] ^ b_x[i]));
      end
   end

   assign cout = carry[N];

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle.
// Optional abort input enabled by defining SEQ_DIVIDER_ABORT_EN.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
`ifdef SEQ_DIVIDER_ABORT_EN
   input  logic             abort,
`endif
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic [WIDTH-1:0] quotient_q, quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic             dbz_q, dbz_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [WIDTH:0]   trial_a, trial_b, trial_sum;
   logic             trial_cout;
   logic             sum_msb_unused;
   logic [WIDTH-1:0] step_rem, step_quo;

   // The shifted partial remainder needs one extra bit before the compare.
   assign trial_a = {rem_q, quo_q[WIDTH-1]};
   assign trial_b = {1'b0, dvsr_q};

   addsub_nbit #(.N(WIDTH + 1)) u_addsub (
      .a    (trial_a),
      .b    (trial_b),
      .ctrl (1'b1),
      .sum  (trial_sum),
      .cout (trial_cout)
   );

   assign sum_msb_unused = trial_sum[WIDTH];
   assign step_rem = trial_cout ? trial_sum[WIDTH-1:0] : trial_a[WIDTH-1:0];
   assign step_quo = {quo_q[WIDTH-2:0], trial_cout};

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvsr_d      = dvsr_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      cnt_d       = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               dvsr_d = divisor;
               quo_d  = dividend;
               rem_d  = '0;
               cnt_d  = '0;
               dbz_d  = 1'b0;
               if (divisor == '0) begin
                  state_d     = DONE;
                  quotient_d  = '1;
                  remainder_d = dividend;
                  dbz_d       = 1'b1;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
`ifdef SEQ_DIVIDER_ABORT_EN
            if (abort) begin
               state_d = IDLE;
            end else
`endif
            begin
               rem_d = step_rem;
               quo_d = step_quo;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_STEP) begin
                  state_d     = DONE;
                  quotient_d  = step_quo;
                  remainder_d = step_rem;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         quo_q       <= '0;
         dvsr_q      <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvsr_q      <= dvsr_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
         cnt_q       <= cnt_d;
      end
   end

   assign busy        = (state_q == CALC);
   assign done        = (state_q == DONE);
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Randomised self-checking bench for seq_divider (WIDTH=4) against a plain
// arithmetic division model; covers abort when SEQ_DIVIDER_ABORT_EN is set.
module tb_seq_divider;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] dividend, divisor;
   logic         busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;
`ifdef SEQ_DIVIDER_ABORT_EN
   logic         abort;
`endif

   int errors = 0;
   int checks = 0;
   int exp_q  = 0;
   int exp_r  = 0;

   always #5 clk = ~clk;

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
`ifdef SEQ_DIVIDER_ABORT_EN
      .abort       (abort),
`endif
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Starts one division from IDLE (called just after a falling edge) and
   // returns one cycle after the done pulse, with the DUT back in IDLE.
   task automatic applyStimulus(input int a, input int b, input bit keep_start);
      int lat;
      bit got;
      int q, r, z;
      z = (b == 0) ? 1 : 0;
      q = (b == 0) ? (1 << W) - 1 : a / b;
      r = (b == 0) ? a : a % b;
      start    = 1'b1;
      dividend = W'(a);
      divisor  = W'(b);
      @(posedge clk);
      #1;
      if (!keep_start) start = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      lat = 1;
      got = 1'b0;
      for (int i = 0; i < 3 * W + 5; i++) begin
         @(negedge clk);
         if (done) begin
            got = 1'b1;
            break;
         end
         if (lat == 1) begin
            checkOutput("busy_in_calc", busy, 1);
            checkOutput("dbz_cleared", div_by_zero, 0);
            checkOutput("quotient_hold", quotient, exp_q);
            checkOutput("remainder_hold", remainder, exp_r);
         end
         lat++;
         dividend = W'($urandom);
         divisor  = W'($urandom);
         if (!keep_start) start = 1'($urandom_range(0, 1));
      end
      if (!keep_start) start = 1'b0;
      checkOutput("done_timeout", got, 1);
      if (got) begin
         checkOutput("latency", lat, (b == 0) ? 1 : W + 1);
         checkOutput("quotient", quotient, q);
         checkOutput("remainder", remainder, r);
         checkOutput("div_by_zero", div_by_zero, z);
      end
      exp_q = q;
      exp_r = r;
      @(negedge clk);
      checkOutput("done_single_pulse", done, 0);
      checkOutput("busy_between_ops", busy, 0);
      checkOutput("quotient_after_done", quotient, exp_q);
      checkOutput("remainder_after_done", remainder, exp_r);
   endtask

   initial begin
      bit saw_done;
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
`ifdef SEQ_DIVIDER_ABORT_EN
      abort    = 1'b0;
`endif
      #3;
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_quotient", quotient, 0);
      checkOutput("reset_remainder", remainder, 0);
      checkOutput("reset_dbz", div_by_zero, 0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] directed vectors");
      applyStimulus(13, 4, 1'b0);
      applyStimulus(3, 7, 1'b0);
      applyStimulus(15, 1, 1'b0);
      applyStimulus(9, 0, 1'b0);
      applyStimulus(0, 5, 1'b0);

      $display("[TB] reset during CALC");
      applyStimulus(9, 0, 1'b0);
      start    = 1'b1;
      dividend = W'(13);
      divisor  = W'(4);
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midreset_busy", busy, 0);
      checkOutput("midreset_done", done, 0);
      checkOutput("midreset_quotient", quotient, 0);
      checkOutput("midreset_remainder", remainder, 0);
      checkOutput("midreset_dbz", div_by_zero, 0);
      saw_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      checkOutput("midreset_no_done", saw_done, 0);
      rst_n = 1'b1;
      exp_q = 0;
      exp_r = 0;
      applyStimulus(14, 5, 1'b0);

      $display("[TB] random single operations");
      for (int n = 0; n < 24; n++)
         applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0);

      $display("[TB] start held high, operands changing every cycle");
      for (int n = 0; n < 10; n++)
         applyStimulus(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b1);
      start = 1'b0;
      @(negedge clk);

`ifdef SEQ_DIVIDER_ABORT_EN
      $display("[TB] abort during CALC");
      applyStimulus(11, 3, 1'b0);
      start    = 1'b1;
      dividend = W'(13);
      divisor  = W'(4);
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_done", done, 0);
      saw_done = 1'b0;
      repeat (W + 2) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      checkOutput("abort_no_done", saw_done, 0);
      checkOutput("abort_quotient", quotient, exp_q);
      checkOutput("abort_remainder", remainder, exp_r);
      checkOutput("abort_dbz", div_by_zero, 0);
      applyStimulus(14, 5, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 The block SHALL have port dividend, input, WIDTH bits: unsigned dividend, captured on the accepting edge.
REQ-006 The block SHALL have port divisor, input, WIDTH bits: unsigned divisor, captured on the accepting edge.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in CALC.
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle pulse that marks valid results.
REQ-009 The block SHALL have port quotient, output, WIDTH bits: result quotient.
REQ-010 The block SHALL have port remainder, output, WIDTH bits: result remainder.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: high with done when the captured divisor was 0.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-013 IDLE with start=1 SHALL capture the operands, clear the working remainder and go to CALC; if divisor==0 it SHALL go directly to DONE instead.
REQ-014 CALC SHALL perform one restoring step per cycle, for exactly WIDTH cycles, MSB first.
REQ-015 Each step SHALL:
- shift {rem, quo} left by one;
- compute rem - divisor through the add/sub sub-module (ctrl=1);
- if carry-out=1 (no borrow), keep the difference and set quo[0]=1;
- otherwise restore rem and set quo[0]=0.
REQ-016 After the WIDTH-th step the FSM SHALL enter DONE; DONE SHALL assert done for one cycle and return to IDLE on the next edge.
REQ-017 Latency SHALL be WIDTH+1 cycles from the accepting edge to done high, and 1 cycle for divide-by-zero.
REQ-018 On divide-by-zero the outputs SHALL be quotient = all ones, remainder = dividend, div_by_zero = 1.
REQ-019 div_by_zero SHALL clear on the next accepted start.
REQ-020 quotient and remainder SHALL update only when entering DONE and SHALL hold until the next result.
REQ-021 start in CALC or DONE SHALL be ignored, with no queueing; a back-to-back start SHALL be accepted only once the FSM is back in IDLE.
REQ-022 Operand changes after the accepting edge SHALL NOT affect the result.
REQ-023 For every result, dividend = quotient*divisor + remainder SHALL hold, with remainder < divisor, for any divisor != 0.

Reset
REQ-024 rst_n=0 SHALL immediately, without waiting for clk, force IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and clear all working registers.
REQ-025 Reset asserted mid-CALC SHALL abandon the operation with no done pulse.
REQ-026 The first start SHALL be honoured on the first rising edge after rst_n deasserts.

Configuration
REQ-027 Macro SEQ_DIVIDER_ABORT_EN, when defined, SHALL add port abort (input, 1 bit); abort=1 in CALC SHALL return the FSM to IDLE on the next edge with no done, and quotient, remainder and div_by_zero unchanged; abort SHALL be ignored in IDLE and DONE.
REQ-028 Without SEQ_DIVIDER_ABORT_EN the abort port SHALL be absent and CALC SHALL always run to completion.

Structure
REQ-029 Package seq_divider_pkg SHALL hold the state enum (IDLE/CALC/DONE) and the default WIDTH constant.
REQ-030 The subtract step SHALL use one sub-module, addsub_nbit: a parameterised ripple-carry adder/subtractor whose ctrl input XORs b and drives carry-in, with outputs sum and cout.
REQ-031 The iteration counter SHALL be $clog2(WIDTH+1) bits wide.

Verification (WIDTH=4)
REQ-032 dividend=13, divisor=4 -> done 5 cycles after acceptance, quotient=3, remainder=1, div_by_zero=0.
REQ-033 dividend=9, divisor=0 -> done 1 cycle after acceptance, quotient=15, remainder=9, div_by_zero=1.
REQ-034 dividend=3, divisor=7 -> quotient=0, remainder=3; dividend=15, divisor=1 -> quotient=15, remainder=0.
REQ-035 start held high continuously with operands changing every cycle -> exactly one accept per IDLE visit, each result matching the operands captured at its accept, busy low between operations.
REQ-036 rst_n pulsed low in the 2nd CALC cycle of 13/4 -> outputs zero immediately, no done; a following 14/5 -> quotient=2, remainder=4.
REQ-037 With SEQ_DIVIDER_ABORT_EN: abort in the 3rd CALC cycle of 13/4 -> IDLE, no done, outputs keep the previous result.
